// File: rtl/soc_irq_ctrl_reg_pkg.sv
// Shared register map, response codes and decode helpers for the soc_irq_ctrl
// AXI-Lite interrupt controller.
package soc_irq_ctrl_reg_pkg;

  localparam int IRQ_ID_W = 5;

  localparam logic [31:0] IRQ_ENABLE_OFFSET  = 32'h00;
  localparam logic [31:0] IRQ_TYPE_OFFSET    = 32'h04;
  localparam logic [31:0] IRQ_PENDING_OFFSET = 32'h08;
  localparam logic [31:0] IRQ_RAW_OFFSET     = 32'h0C;
  localparam logic [31:0] IRQ_ACTIVE_OFFSET  = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_RESP
  } rd_state_e;

  typedef enum logic [2:0] {
    REG_ENABLE,
    REG_TYPE,
    REG_PENDING,
    REG_RAW,
    REG_ACTIVE,
    REG_NONE
  } reg_sel_e;

  // Full-address match: unaligned or unmapped addresses fall through to REG_NONE.
  function automatic reg_sel_e decode_offset(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      IRQ_ENABLE_OFFSET:  sel = REG_ENABLE;
      IRQ_TYPE_OFFSET:    sel = REG_TYPE;
      IRQ_PENDING_OFFSET: sel = REG_PENDING;
      IRQ_RAW_OFFSET:     sel = REG_RAW;
      IRQ_ACTIVE_OFFSET:  sel = REG_ACTIVE;
      default:            sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/soc_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered set request bit.
module soc_irq_prio_enc
  import soc_irq_ctrl_reg_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_irq_ctrl.sv
// AXI-Lite interrupt controller: per-source level/edge capture into pending
// bits, enable masking and a lowest-index-wins combined interrupt.
module soc_irq_ctrl
  import soc_irq_ctrl_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_IRQ      = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,

  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,

  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,

  input  logic [N_IRQ-1:0]        irq_src,
  output logic                    irq_out,
  output logic [IRQ_ID_W-1:0]     irq_id
);

  localparam logic [DATA_WIDTH-1:0] IRQ_MASK = DATA_WIDTH'((64'd1 << N_IRQ) - 64'd1);

  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [3:0]            w_strb_q;
  logic                  wr_go;
  reg_sel_e              wr_sel;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] wr_bits;

  logic [DATA_WIDTH-1:0] enable_q;
  logic [DATA_WIDTH-1:0] type_q;
  logic [DATA_WIDTH-1:0] pending_q;
  logic [N_IRQ-1:0]      src_q;
  logic [DATA_WIDTH-1:0] raw_word;
  logic [DATA_WIDTH-1:0] set_bits;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [DATA_WIDTH-1:0] active_word;

  rd_state_e             rd_state;
  rd_state_e             rd_next;
  reg_sel_e              rd_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  assign wr_go   = aw_done & w_done;
  assign wr_sel  = decode_offset(32'(aw_addr_q));
  assign wr_mask = strb_to_mask(w_strb_q) & IRQ_MASK;
  assign wr_bits = w_data_q & wr_mask;

  // AW and W are captured independently; the commit cycle follows once both are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
    end else begin
      AWREADY <= AWVALID && !AWREADY && !aw_done && !BVALID;
      WREADY  <= WVALID && !WREADY && !w_done && !BVALID;
      if (AWVALID && AWREADY) begin
        aw_done   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (WVALID && WREADY) begin
        w_done   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_go) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  assign raw_word = DATA_WIDTH'(irq_src);
  assign set_bits = ((type_q & raw_word & ~DATA_WIDTH'(src_q)) | (~type_q & raw_word)) & IRQ_MASK;
  assign clr_bits = (wr_go && wr_sel == REG_PENDING) ? wr_bits : '0;

  // Capture runs regardless of ENABLE; a same-cycle set overrides the W1C clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      enable_q  <= '0;
      type_q    <= '0;
      pending_q <= '0;
      src_q     <= '0;
    end else begin
      src_q     <= irq_src;
      pending_q <= (pending_q & ~clr_bits) | set_bits;
      if (wr_go && wr_sel == REG_ENABLE) begin
        enable_q <= (enable_q & ~wr_mask) | wr_bits;
      end
      if (wr_go && wr_sel == REG_TYPE) begin
        type_q <= (type_q & ~wr_mask) | wr_bits;
      end
    end
  end

  soc_irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .req   (pending_q[N_IRQ-1:0] & enable_q[N_IRQ-1:0]),
    .valid (irq_out),
    .id    (irq_id)
  );

  assign active_word = {irq_out, {(DATA_WIDTH-1-IRQ_ID_W){1'b0}}, irq_id};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ARVALID) rd_next = RD_ADDR;
      RD_ADDR: rd_next = ARVALID ? RD_RESP : RD_IDLE;
      RD_RESP: if (RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ARREADY = (rd_state == RD_ADDR);
  assign RVALID  = (rd_state == RD_RESP);
  assign rd_sel  = decode_offset(32'(ARADDR));

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_sel)
      REG_ENABLE:  rd_word = enable_q;
      REG_TYPE:    rd_word = type_q;
      REG_PENDING: rd_word = pending_q;
      REG_RAW:     rd_word = raw_word;
      REG_ACTIVE:  rd_word = active_word;
      default:     rd_err  = 1'b1;
    endcase
  end

  // Response is latched at the AR handshake and held untouched until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (rd_state == RD_ADDR && ARVALID) begin
      RDATA <= rd_word;
      RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Directed self-checking bench for soc_irq_ctrl: capture modes, priority,
// masking, strobes, error responses and AXI-Lite handshake corner cases.
module tb_soc_irq_ctrl;
  import soc_irq_ctrl_reg_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NI = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic [NI-1:0] irq_src;
  logic          irq_out;
  logic [4:0]    irq_id;

  int   check_count = 0;
  int   pass_count  = 0;
  logic b_held_ok;
  logic aw_leaked;

  always #5 ACLK = ~ACLK;

  soc_irq_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_IRQ      (NI)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .irq_src (irq_src),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [NI-1:0] src, input int hold);
    irq_src = src;
    repeat (hold) @(posedge ACLK);
    #1;
  endtask

  // W may lead AW by w_lead cycles; BREADY is withheld b_delay cycles, optionally
  // presenting a second AW during that window to confirm it is refused.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_delay,
                           input bit probe_aw, output logic [1:0] resp);
    bit aw_left, w_left, aw_fire, w_fire, got_b;
    aw_left = 1'b1;
    w_left  = 1'b1;
    got_b   = 1'b0;
    resp    = 2'b11;
    AWADDR  = addr[AW-1:0];
    WDATA   = data;
    WSTRB   = strb;
    WVALID  = 1'b1;
    for (int c = 0; c < 40 && (aw_left || w_left); c++) begin
      if (c == w_lead && aw_left) AWVALID = 1'b1;
      @(negedge ACLK);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      #1;
      if (aw_fire) begin AWVALID = 1'b0; aw_left = 1'b0; end
      if (w_fire)  begin WVALID  = 1'b0; w_left  = 1'b0; end
    end
    if (aw_left || w_left) begin
      checkOutput("wr_accept_timeout", 32'd0, 32'd1);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      return;
    end
    for (int c = 0; c < 20 && !got_b; c++) begin
      @(negedge ACLK);
      if (BVALID) got_b = 1'b1;
    end
    if (!got_b) begin
      checkOutput("wr_resp_timeout", 32'd0, 32'd1);
      return;
    end
    resp = BRESP;
    if (probe_aw) begin
      AWADDR  = 5'h04;
      AWVALID = 1'b1;
    end
    for (int c = 0; c < b_delay; c++) begin
      @(negedge ACLK);
      if (!BVALID) b_held_ok = 1'b0;
      if (AWREADY) aw_leaked = 1'b1;
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    BREADY  = 1'b0;
    AWVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit fired, fire, got_r;
    fired   = 1'b0;
    got_r   = 1'b0;
    data    = 32'hDEAD_BEEF;
    resp    = 2'b11;
    ARADDR  = addr[AW-1:0];
    ARVALID = 1'b1;
    for (int c = 0; c < 20 && !fired; c++) begin
      @(negedge ACLK);
      fire = ARREADY;
      @(posedge ACLK);
      #1;
      if (fire) begin ARVALID = 1'b0; fired = 1'b1; end
    end
    if (!fired) begin
      checkOutput("rd_accept_timeout", 32'd0, 32'd1);
      ARVALID = 1'b0;
      return;
    end
    for (int c = 0; c < 20 && !got_r; c++) begin
      @(negedge ACLK);
      if (RVALID) got_r = 1'b1;
    end
    if (!got_r) begin
      checkOutput("rd_resp_timeout", 32'd0, 32'd1);
      return;
    end
    data   = RDATA;
    resp   = RRESP;
    RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          b_extra;

    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; irq_src = '0;

    repeat (3) @(negedge ACLK);
    checkOutput("rst_irq_out", irq_out, 0);
    checkOutput("rst_irq_id", irq_id, 0);
    checkOutput("rst_readys", {AWREADY, WREADY, ARREADY}, 0);
    checkOutput("rst_valids", {BVALID, RVALID}, 0);
    checkOutput("rst_resp_data", {RDATA ^ 32'h0, 28'h0, BRESP | RRESP}, 0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    $display("[TB] level source");
    axi_write(32'h00, 32'h1, 4'hF, 0, 0, 0, r);
    checkOutput("enable_wr_bresp", r, RESP_OKAY);
    axi_write(32'h04, 32'h0, 4'hF, 0, 0, 0, r);
    applyStimulus(8'h01, 2);
    checkOutput("level_irq_out", irq_out, 1);
    checkOutput("level_irq_id", irq_id, 0);
    axi_write(32'h08, 32'h1, 4'hF, 0, 0, 0, r);
    axi_read(32'h08, d, r);
    checkOutput("level_w1c_while_held", d, 32'h1);
    applyStimulus(8'h00, 1);
    axi_write(32'h08, 32'h1, 4'hF, 0, 0, 0, r);
    checkOutput("level_cleared_irq_out", irq_out, 0);

    $display("[TB] edge source");
    axi_write(32'h04, 32'h4, 4'hF, 0, 0, 0, r);
    axi_write(32'h00, 32'h4, 4'hF, 0, 0, 0, r);
    applyStimulus(8'h04, 1);
    applyStimulus(8'h00, 3);
    axi_read(32'h08, d, r);
    checkOutput("edge_pending_sticky", d, 32'h4);
    checkOutput("edge_irq_id", {irq_out, irq_id}, {1'b1, 5'd2});
    axi_write(32'h08, 32'h4, 4'hF, 0, 0, 0, r);
    axi_read(32'h08, d, r);
    checkOutput("edge_w1c_pending", d, 32'h0);

    $display("[TB] priority");
    axi_write(32'h00, 32'hFF, 4'hF, 0, 0, 0, r);
    axi_write(32'h04, 32'hFF, 4'hF, 0, 0, 0, r);
    applyStimulus(8'h28, 1);
    applyStimulus(8'h00, 1);
    axi_read(32'h10, d, r);
    checkOutput("prio_active_3", d, 32'h8000_0003);
    axi_write(32'h08, 32'h08, 4'hF, 0, 0, 0, r);
    axi_read(32'h10, d, r);
    checkOutput("prio_active_5", d, 32'h8000_0005);
    axi_write(32'h08, 32'h20, 4'hF, 0, 0, 0, r);
    axi_read(32'h10, d, r);
    checkOutput("prio_active_none", d, 32'h0);

    $display("[TB] masking");
    axi_write(32'h00, 32'h0, 4'hF, 0, 0, 0, r);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h00, 1);
    checkOutput("mask_irq_out_off", irq_out, 0);
    axi_read(32'h08, d, r);
    checkOutput("mask_pending", d, 32'h2);
    axi_write(32'h00, 32'h2, 4'hF, 0, 0, 0, r);
    checkOutput("mask_irq_on_after_enable", {irq_out, irq_id}, {1'b1, 5'd1});
    axi_write(32'h08, 32'h2, 4'hF, 0, 0, 0, r);

    $display("[TB] strobes and register width");
    axi_write(32'h00, 32'h5A, 4'hF, 0, 0, 0, r);
    axi_write(32'h00, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, r);
    axi_read(32'h00, d, r);
    checkOutput("strb_lane_ignored", d, 32'h5A);
    axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    axi_read(32'h00, d, r);
    checkOutput("enable_width", d, 32'hFF);

    $display("[TB] errors and raw");
    axi_write(32'h14, 32'h0, 4'hF, 0, 0, 0, r);
    checkOutput("bad_addr_bresp", r, RESP_SLVERR);
    axi_read(32'h00, d, r);
    checkOutput("bad_addr_no_side_effect", d, 32'hFF);
    axi_read(32'h18, d, r);
    checkOutput("bad_addr_rresp", r, RESP_SLVERR);
    checkOutput("bad_addr_rdata", d, 32'h0);
    applyStimulus(8'h81, 1);
    axi_read(32'h0C, d, r);
    checkOutput("raw_readback", d, 32'h81);
    applyStimulus(8'h00, 1);
    axi_write(32'h08, 32'hFF, 4'hF, 0, 0, 0, r);

    $display("[TB] handshake corners");
    axi_write(32'h04, 32'h0F, 4'hF, 3, 0, 0, r);
    checkOutput("w_lead_bresp", r, RESP_OKAY);
    b_extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK);
      if (BVALID) b_extra++;
    end
    checkOutput("w_lead_single_b", b_extra, 0);
    @(posedge ACLK);
    #1;
    axi_read(32'h04, d, r);
    checkOutput("w_lead_type", d, 32'h0F);

    b_held_ok = 1'b1;
    aw_leaked = 1'b0;
    axi_write(32'h00, 32'h03, 4'hF, 0, 4, 1, r);
    checkOutput("bready_low_bvalid_held", b_held_ok, 1);
    checkOutput("bready_low_aw_refused", aw_leaked, 0);
    axi_read(32'h00, d, r);
    checkOutput("bready_low_enable", d, 32'h03);

    axi_write(32'h04, 32'hFF, 4'hF, 0, 0, 0, r);
    applyStimulus(8'h10, 1);
    applyStimulus(8'h00, 1);
    fork
      axi_write(32'h08, 32'h10, 4'hF, 0, 0, 0, r);
      begin
        repeat (2) @(posedge ACLK);
        #1 irq_src = 8'h10;
        @(posedge ACLK);
        #1 irq_src = 8'h00;
      end
    join
    axi_read(32'h08, d, r);
    checkOutput("set_wins_over_w1c", d, 32'h10);
    axi_write(32'h08, 32'h10, 4'hF, 0, 0, 0, r);
    axi_read(32'h08, d, r);
    checkOutput("w1c_after_set_race", d, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/soc_irq_ctrl.md
# soc_irq_ctrl

AXI-Lite interrupt controller that sits directly downstream of the SoC timer and other peripheral interrupt sources. It aggregates up to `N_IRQ` interrupt lines, for example timer `irq`, into per-source pending bits. Each source is configurable as level- or edge-sensitive. The block drives one enabled, combined interrupt to the CPU and reports the highest-priority active source ID.

## Interface
- `ADDR_WIDTH`, 5: AXI-Lite byte-address width.
- `DATA_WIDTH`, 32: AXI-Lite data width. Fixed at 32.
- `N_IRQ`, 8: number of interrupt sources, 1..32.
- `ACLK` input 1: clock.
- `ARESETN` input 1: reset, asynchronous, active-low.
- `AWADDR/AWVALID/AWREADY`, `WDATA/WSTRB/WVALID/WREADY`, `BRESP/BVALID/BREADY`: AXI-Lite write channels. Widths are per `ADDR_WIDTH`/`DATA_WIDTH`.
- `ARADDR/ARVALID/ARREADY`, `RDATA/RRESP/RVALID/RREADY`: AXI-Lite read channels.
- `irq_src` input `N_IRQ`: raw interrupt lines, synchronous to `ACLK`. Bit 0 is the timer `irq`.
- `irq_out` output 1: `|(pending & enable)`.
- `irq_id` output 5: index of the lowest-numbered bit set in `pending & enable`. 0 when none.

## Operation
- **Register map** (word offsets; any other address returns SLVERR, writes ignored, read data 0):
  - 0x00 ENABLE: RW.
  - 0x04 TYPE: RW. 1 = edge, 0 = level.
  - 0x08 PENDING: R, write-1-to-clear.
  - 0x0C RAW: RO, current `irq_src`.
  - 0x10 ACTIVE: RO. `{irq_out, 26'b0, irq_id}`.
- **Register width:** bits at or above `N_IRQ` read 0 and ignore writes.
- **WSTRB:** byte lanes with strobe 0 are not written. For PENDING, only strobed bytes clear.
- **Level source:** `pending[i]` is set every cycle that `irq_src[i]` is 1.
- **Edge source:** `pending[i]` is set on a 0→1 transition of `irq_src[i]` against the registered previous value `src_q[i]`.
- **Clearing:** `pending[i]` is cleared only by a W1C write. If set and clear occur in the same cycle, set wins. A level source that is still asserted therefore stays pending.
- **ENABLE does not gate capture.** Disabled sources still accumulate pending; they only do not contribute to `irq_out`/`irq_id`.
- **Priority:** fixed. The lowest index wins.

## Timing
- **Reset values:**
  - Channel signals: all READY/VALID 0; BRESP, RRESP, RDATA 0.
  - Registers: ENABLE, TYPE, pending, and `src_q` all 0.
  - Outputs: `irq_out` 0, `irq_id` 0.
- **Edge source held high through reset release:** this counts as an edge in the first cycle after reset, because `src_q` resets to 0.
- **Write path:**
  - AW and W are accepted independently. Each READY pulses for exactly one cycle, in the cycle after its VALID is seen, while no write is outstanding.
  - The cycle after both are captured: registers update and BVALID rises with BRESP for that same transaction (OKAY 00 / SLVERR 10).
  - BVALID holds until BREADY. No new AW/W is accepted while BVALID=1.
- **Read path:**
  - ARREADY pulses one cycle after ARVALID, when no read is outstanding.
  - The next cycle, RVALID=1 with RDATA/RRESP. Both are held stable until RREADY.
  - One read is outstanding at a time. A new AR is accepted only after the R handshake completes.
- **Interrupt latency:**
  - `irq_src` change sampled at edge k → `pending` updated at k.
  - `irq_out`/`irq_id` are combinational from `pending & enable`, so valid in the same cycle as the pending update.
  - A W1C write clears pending on the same edge as BVALID rises.
- **ENABLE write:** takes effect on `irq_out` in the cycle after the write edge.
- **Mid-transaction reset:** an ARESETN assertion mid-transaction aborts all channels immediately; no B or R response is issued.

## Structure
- Package `soc_irq_ctrl_reg_pkg`:
  - Register offsets: `IRQ_ENABLE_OFFSET`, `IRQ_TYPE_OFFSET`, `IRQ_PENDING_OFFSET`, `IRQ_RAW_OFFSET`, `IRQ_ACTIVE_OFFSET`.
  - `RESP_OKAY`/`RESP_SLVERR` constants.
  - `IRQ_ID_W = 5`.
- Sub-module `soc_irq_prio_enc`: parameterised `N_IRQ`-bit lowest-index priority encoder. Inputs: masked pending. Outputs: `valid` and `id`.
- Top level contains the AXI-Lite channel control, register file, and the pending capture logic.

## Test plan
- **Level source:** ENABLE=0x1, TYPE=0. Hold `irq_src[0]`=1 → `irq_out`=1, `irq_id`=0. Write PENDING=0x1 while the source is held → pending stays 1. Drop the source, then W1C → `irq_out`=0.
- **Edge source:** TYPE=0x4, ENABLE=0x4. 1-cycle pulse on `irq_src[2]` → PENDING reads 0x4 and stays after the pulse ends. W1C 0x4 → PENDING reads 0x0.
- **Priority:** ENABLE=0xFF, TYPE=0xFF. Pulse bits 5 and 3 together → ACTIVE reads 0x8000_0003. Clear bit 3 → ACTIVE reads 0x8000_0005.
- **Masking:** ENABLE=0. Pulse `irq_src[1]` (edge) → `irq_out`=0 and PENDING=0x2. Write ENABLE=0x2 → `irq_out`=1 the next cycle.
- **Errors:** write to 0x14 → BRESP=10, no register changes. Read 0x18 → RRESP=10, RDATA=0.
- **Handshake:**
  - W presented 3 cycles before AW → a single B response after AW is accepted.
  - BREADY held low for 4 cycles → BVALID stays 1 and a second AWVALID is not accepted.
  - Same-cycle set and W1C on an edge source → pending stays 1.
